// File: rtl/decode_stage.sv
// RV32I-subset decode stage: 32-entry register file with write-through bypass,
// control/immediate decode, and the Decode/Execute pipeline register.
module decode_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] InstrD,
  input  logic [WORD_SIZE-1:0] PCD,
  input  logic [WORD_SIZE-1:0] PCPlus4D,
  input  logic                 RegWriteW,
  input  logic [4:0]           RdW,
  input  logic [WORD_SIZE-1:0] ResultW,
  input  logic                 FlushE,
  output logic [4:0]           Rs1D,
  output logic [4:0]           Rs2D,
  output logic                 RegWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic [2:0]           ALUControlE,
  output logic                 ALUSrcE,
  output logic [WORD_SIZE-1:0] RD1E,
  output logic [WORD_SIZE-1:0] RD2E,
  output logic [WORD_SIZE-1:0] PCE,
  output logic [WORD_SIZE-1:0] PCPlus4E,
  output logic [WORD_SIZE-1:0] ImmExtE,
  output logic [4:0]           Rs1E,
  output logic [4:0]           Rs2E,
  output logic [4:0]           RdE
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [WORD_SIZE-1:0] regFile [REG_COUNT];

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [4:0]           rdD;
  logic                 regWriteD, memWriteD, jumpD, branchD, aluSrcD;
  logic [1:0]           resultSrcD;
  logic [2:0]           aluControlD;
  logic [WORD_SIZE-1:0] immExtD, rd1D, rd2D;
  logic                 aluOpValid;
  logic [2:0]           aluOpCtrl;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rdD    = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  // Bypass lets a same-cycle writeback reach the reader; x0 never bypasses.
  assign rd1D = (Rs1D == 5'd0) ? '0 :
                (RegWriteW && RdW == Rs1D) ? ResultW : regFile[Rs1D];
  assign rd2D = (Rs2D == 5'd0) ? '0 :
                (RegWriteW && RdW == Rs2D) ? ResultW : regFile[Rs2D];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regFile[i] <= '0;
    end else if (RegWriteW && RdW != 5'd0) begin
      regFile[RdW] <= ResultW;
    end
  end

  // funct3 map shared by R-type and I-ALU; only R-type honours funct7[5].
  always_comb begin
    aluOpValid = 1'b1;
    aluOpCtrl  = ALU_ADD;
    case (funct3)
      3'b000:  aluOpCtrl = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  aluOpCtrl = ALU_SLT;
      3'b110:  aluOpCtrl = ALU_OR;
      3'b111:  aluOpCtrl = ALU_AND;
      default: aluOpValid = 1'b0;
    endcase
  end

  always_comb begin
    regWriteD   = 1'b0;
    memWriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    resultSrcD  = 2'b00;
    aluControlD = ALU_ADD;
    immExtD     = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[31:20]};
    case (opcode)
      OP_R: if (aluOpValid) begin
        regWriteD   = 1'b1;
        aluControlD = aluOpCtrl;
      end
      OP_I: if (aluOpValid) begin
        regWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        aluControlD = aluOpCtrl;
      end
      OP_LW: if (funct3 == 3'b010) begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b01;
      end
      OP_SW: begin
        immExtD = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
        if (funct3 == 3'b010) begin
          memWriteD = 1'b1;
          aluSrcD   = 1'b1;
        end
      end
      OP_BEQ: begin
        immExtD = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                   InstrD[11:8], 1'b0};
        if (funct3 == 3'b000) begin
          branchD     = 1'b1;
          aluControlD = ALU_SUB;
        end
      end
      OP_JAL: begin
        immExtD    = {{(WORD_SIZE-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                      InstrD[30:21], 1'b0};
        jumpD      = 1'b1;
        regWriteD  = 1'b1;
        resultSrcD = 2'b10;
      end
      default: ;
    endcase
  end

  // Decode/Execute pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= regWriteD;
      ResultSrcE  <= resultSrcD;
      MemWriteE   <= memWriteD;
      JumpE       <= jumpD;
      BranchE     <= branchD;
      ALUControlE <= aluControlD;
      ALUSrcE     <= aluSrcD;
      RD1E        <= rd1D;
      RD2E        <= rd2D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      ImmExtE     <= immExtD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rdD;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors checked with
// immediate assertions one cycle after each instruction is presented.
module tb_decode_stage;

  logic        clk, rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;

  int checks = 0;
  int errors = 0;

  decode_stage #(.WORD_SIZE(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control word packed as {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc}
  task automatic chkCtrl(input string tag, input logic [9:0] exp);
    chk(tag, {22'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
              ALUControlE, ALUSrcE}, {22'd0, exp});
  endtask

  task automatic chkAllZero(input string tag);
    chkCtrl({tag, "_ctrl"}, 10'd0);
    chk({tag, "_rd1"}, RD1E, 32'd0);
    chk({tag, "_rd2"}, RD2E, 32'd0);
    chk({tag, "_pc"}, PCE, 32'd0);
    chk({tag, "_pc4"}, PCPlus4E, 32'd0);
    chk({tag, "_imm"}, ImmExtE, 32'd0);
    chk({tag, "_regs"}, {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; InstrD = 32'h0000_0000; PCD = 32'h0; PCPlus4D = 32'h0;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0; FlushE = 1'b0;
    tick;
    chkAllZero("reset");
    InstrD = 32'h0050_0093; PCD = 32'h10; PCPlus4D = 32'h14;
    tick;
    chkAllZero("reset_held");
    #2 rst = 1'b1;

    // addi x1,x0,5
    tick;
    chkCtrl("addi_ctrl", {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1});
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_rd", {27'd0, RdE}, 32'd1);
    chk("addi_rd1", RD1E, 32'd0);
    chk("addi_pc", PCE, 32'h10);
    chk("addi_pc4", PCPlus4E, 32'h14);

    // add x3,x1,x2 with same-cycle writeback of x1=7
    InstrD = 32'h0020_81B3; RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'd7;
    #1;
    chk("add_rs1d", {27'd0, Rs1D}, 32'd1);
    chk("add_rs2d", {27'd0, Rs2D}, 32'd2);
    tick;
    chkCtrl("add_ctrl", {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0});
    chk("add_bypass_rd1", RD1E, 32'd7);
    chk("add_rd2", RD2E, 32'd0);
    chk("add_rd", {27'd0, RdE}, 32'd3);
    chk("add_rs1e", {27'd0, Rs1E}, 32'd1);
    chk("add_rs2e", {27'd0, Rs2E}, 32'd2);
    RegWriteW = 1'b0;

    // sub x3,x1,x2: x1 now comes from storage
    InstrD = 32'h4020_81B3;
    tick;
    chkCtrl("sub_ctrl", {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0});
    chk("sub_stored_rd1", RD1E, 32'd7);

    // lw x5,8(x2)
    InstrD = 32'h0081_2283;
    tick;
    chkCtrl("lw_ctrl", {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1});
    chk("lw_imm", ImmExtE, 32'd8);

    // sw x5,12(x2)
    InstrD = 32'h0051_2623;
    tick;
    chkCtrl("sw_ctrl", {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1});
    chk("sw_imm", ImmExtE, 32'd12);

    // beq x1,x2,-8 at PC 0x20
    InstrD = 32'hFE20_8CE3; PCD = 32'h20; PCPlus4D = 32'h24;
    tick;
    chkCtrl("beq_ctrl", {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0});
    chk("beq_imm", ImmExtE, 32'hFFFF_FFF8);
    chk("beq_pc", PCE, 32'h20);
    chk("beq_rd1", RD1E, 32'd7);

    // Same beq flushed
    FlushE = 1'b1;
    tick;
    chkAllZero("flush");
    FlushE = 1'b0;

    // jal x1,16
    InstrD = 32'h0100_00EF;
    tick;
    chkCtrl("jal_ctrl", {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0});
    chk("jal_imm", ImmExtE, 32'd16);

    // addi x1,x0,-1: negative I-immediate
    InstrD = 32'hFFF0_0093;
    tick;
    chk("addi_neg_imm", ImmExtE, 32'hFFFF_FFFF);

    // ori x1,x0,1
    InstrD = 32'h0010_6093;
    tick;
    chkCtrl("ori_ctrl", {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1});

    // slli (funct3 001) is unlisted: bubble controls, data still registered
    InstrD = 32'h0010_1093;
    tick;
    chkCtrl("bad_funct3_ctrl", 10'd0);
    chk("bad_funct3_imm", ImmExtE, 32'd1);
    chk("bad_funct3_rd", {27'd0, RdE}, 32'd1);

    // Unknown opcode
    InstrD = 32'h0000_007F;
    tick;
    chkCtrl("bad_op_ctrl", 10'd0);

    // Write to x0 is ignored, including the bypass path
    InstrD = 32'h0050_0093; RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h0000_FFFF;
    tick;
    chk("x0_bypass", RD1E, 32'd0);
    RegWriteW = 1'b0;
    tick;
    chk("x0_stored", RD1E, 32'd0);
    chk("held_instr_rw", {31'd0, RegWriteE}, 32'd1);

    // Asynchronous reset mid-run, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    chkAllZero("async_reset");
    #1 rst = 1'b1;

    // Register file was cleared: x1 (previously 7) reads 0
    InstrD = 32'h0020_81B3;
    tick;
    chk("rf_cleared_rd1", RD1E, 32'd0);
    chk("post_reset_rd", {27'd0, RdE}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
